nodf_handshake_tracker: RTL and testbench
=========================================

// Module: nodf_handshake_tracker
// PURPOSE
// - Per-module ap_ctrl handshake tracker for non-dataflow HLS blocks; one instance per monitored block.
// - Samples ap_start/ap_ready/ap_done/ap_continue plus a global finish.
// - Produces live status, transaction counts, start-to-done latency statistics and stall accounting.
// - Unused slots tie inputs to constant 0 and must report IDLE with all counts at zero.
// PARAMETERS
// - CNT_W     32  width of all counters and timestamps
// - TS_DEPTH  4   depth of the start-timestamp FIFO (max outstanding transactions; power of 2)
// PORTS
// - clock            in   1      single clock, all logic on posedge
// - reset            in   1      synchronous, active-high reset
// - ap_start         in   1      block start request
// - ap_ready         in   1      block accepted inputs
// - ap_done          in   1      block result valid
// - ap_continue      in   1      downstream accepts result (tie 1 when absent)
// - finish           in   1      end of simulation/run; freezes tracker
// - status           out  2      0 IDLE, 1 ACTIVE, 2 STALL, 3 FINISHED
// - start_cnt        out  CNT_W  accepted starts (ap_start&ap_ready)
// - done_cnt         out  CNT_W  accepted completions (ap_done&ap_continue)
// - outstanding      out  $clog2(TS_DEPTH)+1  timestamps currently held
// - last_lat         out  CNT_W  latency of most recent completion
// - min_lat          out  CNT_W  minimum latency
// - max_lat          out  CNT_W  maximum latency
// - stall_cnt        out  CNT_W  cycles with ap_done=1, ap_continue=0
// - busy_cnt         out  CNT_W  cycles with outstanding>0
// - ts_overflow      out  1      sticky: start while FIFO full
// - orphan_done      out  1      sticky: done with no matching start
// BEHAVIOUR
// - Reset (sync, high): all counters, lat outputs, flags, FIFO = 0; min_lat = all-ones; status = IDLE.
// - cyc: free-running CNT_W internal cycle counter, 0 in first post-reset cycle; +1/cycle until FINISHED.
// - Start handshake (ap_start&ap_ready at posedge): start_cnt+1; push cyc into FIFO.
//   - FIFO full: set ts_overflow, drop timestamp, still count the start.
// - Done handshake (ap_done&ap_continue at posedge): done_cnt+1; pop head ts.
//   - last_lat = cyc - ts (modulo 2^CNT_W).
//   - min_lat = min(min_lat, last_lat); max_lat = max(max_lat, last_lat).
//   - FIFO empty and no same-cycle start: set orphan_done, lat outputs unchanged.
// - Same-cycle start+done: pop precedes push.
//   - Empty FIFO: bypass, last_lat = 0, no push, outstanding stays 0.
//   - Full FIFO: pop then push, no overflow.
// - All counters saturate at 2^CNT_W-1; no wrap.
// - stall_cnt +1 each cycle ap_done=1 && ap_continue=0; busy_cnt +1 each cycle outstanding>0 (registered value).
// - Status (registered, next-cycle, highest priority first):
//   - FINISHED: finish sampled 1.
//   - STALL: ap_done && !ap_continue.
//   - ACTIVE: next outstanding>0.
//   - IDLE: otherwise.
// - Finish: events in the cycle finish is sampled high are still counted.
//   - Thereafter all outputs frozen; FINISHED held until reset.
// - Reset asserted mid-transaction discards FIFO contents; no latency recorded.
// - Inputs treated as synchronous; no X-filtering; ap_ready without ap_start is ignored.
// TESTING
// - Start@cyc3, done@cyc10 -> start_cnt=1, done_cnt=1, last/min/max_lat=7, status ACTIVE for cycles 4..10, IDLE after.
// - Start and done same cycle, FIFO empty -> last_lat=0, outstanding=0, orphan_done=0.
// - 5 starts, no done (TS_DEPTH=4) -> outstanding=4, ts_overflow=1, start_cnt=5.
// - ap_done=1, ap_continue=0 for 3 cycles then 1 -> stall_cnt=3, status STALL then done_cnt+1.
// - All inputs 0 for 100 cycles -> every count 0, min_lat=all-ones, status IDLE.
// - finish=1 at cyc 20 with start at 20 -> start_cnt includes it; status FINISHED; counts frozen until reset.

Source files
------------

// File: rtl/nodf_hs_if.sv
// ap_ctrl handshake bundle observed by nodf_handshake_tracker.
// The monitored block (or its stand-in) is the master.
interface nodf_hs_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_ready,
        output ap_done,
        output ap_continue
    );

    modport slave (
        input ap_start,
        input ap_ready,
        input ap_done,
        input ap_continue
    );
endinterface

// File: rtl/nodf_handshake_tracker.sv
// Handshake tracker for one non-dataflow HLS block: status, counts,
// start-to-done latency statistics and stall accounting.
module nodf_handshake_tracker #(
    parameter int CNT_W    = 32,
    parameter int TS_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    nodf_hs_if.slave                    hs,
    input  logic                        finish,
    output logic [1:0]                  status,
    output logic [CNT_W-1:0]            start_cnt,
    output logic [CNT_W-1:0]            done_cnt,
    output logic [$clog2(TS_DEPTH):0]   outstanding,
    output logic [CNT_W-1:0]            last_lat,
    output logic [CNT_W-1:0]            min_lat,
    output logic [CNT_W-1:0]            max_lat,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            busy_cnt,
    output logic                        ts_overflow,
    output logic                        orphan_done
);
    localparam int AW = $clog2(TS_DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STALL    = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ts_mem [TS_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    logic             frozen, st, dn, stall;
    logic             empty, full;
    logic             pop, push, bypass, orphan, ovf, lat_upd;
    logic [CNT_W-1:0] lat_new;
    logic [OW-1:0]    occ_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        frozen  = (state_q == FINISHED);
        st      = hs.ap_start & hs.ap_ready;
        dn      = hs.ap_done & hs.ap_continue;
        stall   = hs.ap_done & ~hs.ap_continue;
        empty   = (outstanding == '0);
        full    = (outstanding == OW'(TS_DEPTH));
        pop     = dn & ~empty;
        // start and done together on an empty FIFO: zero-latency pass-through
        bypass  = dn & empty & st;
        orphan  = dn & empty & ~st;
        push    = st & ~bypass & (~full | pop);
        ovf     = st & full & ~pop;
        lat_upd = pop | bypass;
        lat_new = bypass ? '0 : cyc - ts_mem[rd_ptr];
        occ_next = outstanding + OW'(push) - OW'(pop);
    end

    always_comb begin
        state_d = IDLE;
        if (frozen || finish)
            state_d = FINISHED;
        else if (stall)
            state_d = STALL;
        else if (occ_next != '0)
            state_d = ACTIVE;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign status = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc         <= '0;
            start_cnt   <= '0;
            done_cnt    <= '0;
            stall_cnt   <= '0;
            busy_cnt    <= '0;
            outstanding <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            last_lat    <= '0;
            min_lat     <= '1;
            max_lat     <= '0;
            ts_overflow <= 1'b0;
            orphan_done <= 1'b0;
            for (int i = 0; i < TS_DEPTH; i++)
                ts_mem[i] <= '0;
        end else if (!frozen) begin
            cyc <= cyc + CNT_W'(1);
            if (st)
                start_cnt <= sat_inc(start_cnt);
            if (dn)
                done_cnt <= sat_inc(done_cnt);
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (outstanding != '0)
                busy_cnt <= sat_inc(busy_cnt);
            if (push) begin
                ts_mem[wr_ptr] <= cyc;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            outstanding <= occ_next;
            if (lat_upd) begin
                last_lat <= lat_new;
                if (lat_new < min_lat)
                    min_lat <= lat_new;
                if (lat_new > max_lat)
                    max_lat <= lat_new;
            end
            if (ovf)
                ts_overflow <= 1'b1;
            if (orphan)
                orphan_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nodf_handshake_tracker.sv
// Self-checking bench for nodf_handshake_tracker: a vector table run
// through an expectation queue plus directed multi-cycle sequences.
module tb_nodf_handshake_tracker;
    localparam int CNT_W    = 32;
    localparam int TS_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic finish = 1'b0;

    logic [1:0]       status;
    logic [CNT_W-1:0] start_cnt, done_cnt, last_lat, min_lat, max_lat;
    logic [CNT_W-1:0] stall_cnt, busy_cnt;
    logic [2:0]       outstanding;
    logic             ts_overflow, orphan_done;

    nodf_hs_if hs ();

    nodf_handshake_tracker #(.CNT_W(CNT_W), .TS_DEPTH(TS_DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .hs          (hs.slave),
        .finish      (finish),
        .status      (status),
        .start_cnt   (start_cnt),
        .done_cnt    (done_cnt),
        .outstanding (outstanding),
        .last_lat    (last_lat),
        .min_lat     (min_lat),
        .max_lat     (max_lat),
        .stall_cnt   (stall_cnt),
        .busy_cnt    (busy_cnt),
        .ts_overflow (ts_overflow),
        .orphan_done (orphan_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       s, r, d, c;
        logic [1:0] st;
        int         sc, dc, out, lat;
    } vec_t;

    vec_t tbl [12];
    vec_t sbq [$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic d,
                         input logic c, input logic f);
        @(negedge clock);
        hs.ap_start    = s;
        hs.ap_ready    = r;
        hs.ap_done     = d;
        hs.ap_continue = c;
        finish         = f;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        hs.ap_start    = 1'b0;
        hs.ap_ready    = 1'b0;
        hs.ap_done     = 1'b0;
        hs.ap_continue = 1'b0;
        finish         = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t e;
        // start in cycle 3, done in cycle 10 -> latency 7
        tbl[0]  = '{0, 0, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 2'd1, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 2'd1, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 1, 2'd0, 1, 1, 0, 7};
        tbl[11] = '{0, 0, 0, 0, 2'd0, 1, 1, 0, 7};

        do_reset();
        chk("rst.status", 32'(status), 0);
        chk("rst.start_cnt", start_cnt, 0);
        chk("rst.outstanding", 32'(outstanding), 0);
        chk("rst.min_lat", min_lat, 32'hffff_ffff);
        chk("rst.max_lat", max_lat, 0);

        for (int k = 0; k < 12; k++) begin
            sbq.push_back(tbl[k]);
            drive(tbl[k].s, tbl[k].r, tbl[k].d, tbl[k].c, 0);
            e = sbq.pop_front();
            chk($sformatf("vec%0d.status", k), 32'(status), 32'(e.st));
            chk($sformatf("vec%0d.start_cnt", k), start_cnt, e.sc);
            chk($sformatf("vec%0d.done_cnt", k), done_cnt, e.dc);
            chk($sformatf("vec%0d.outstanding", k), 32'(outstanding), e.out);
            chk($sformatf("vec%0d.last_lat", k), last_lat, e.lat);
        end
        chk("s1.min_lat", min_lat, 7);
        chk("s1.max_lat", max_lat, 7);
        chk("s1.busy_cnt", busy_cnt, 7);
        chk("s1.orphan", 32'(orphan_done), 0);

        // start and done together on an empty FIFO
        do_reset();
        drive(1, 1, 1, 1, 0);
        chk("byp.start_cnt", start_cnt, 1);
        chk("byp.done_cnt", done_cnt, 1);
        chk("byp.last_lat", last_lat, 0);
        chk("byp.min_lat", min_lat, 0);
        chk("byp.outstanding", 32'(outstanding), 0);
        chk("byp.orphan", 32'(orphan_done), 0);
        chk("byp.status", 32'(status), 0);

        // five starts, no done
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 1, 0, 0, 0);
        chk("ovf4.flag", 32'(ts_overflow), 0);
        drive(1, 1, 0, 0, 0);
        chk("ovf5.outstanding", 32'(outstanding), 4);
        chk("ovf5.flag", 32'(ts_overflow), 1);
        chk("ovf5.start_cnt", start_cnt, 5);
        chk("ovf5.status", 32'(status), 1);

        // full FIFO pop+push, overflow, drain, orphan
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 0);
        chk("fpp.last_lat", last_lat, 4);
        chk("fpp.outstanding", 32'(outstanding), 4);
        chk("fpp.ovf", 32'(ts_overflow), 0);
        drive(1, 1, 0, 0, 0);
        chk("fpp.ovf_after", 32'(ts_overflow), 1);
        chk("fpp.start_cnt", start_cnt, 6);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 0);
            chk($sformatf("drain%0d.last_lat", i), last_lat, 5);
        end
        chk("drain.outstanding", 32'(outstanding), 0);
        chk("drain.min_lat", min_lat, 4);
        chk("drain.max_lat", max_lat, 5);
        drive(0, 0, 1, 1, 0);
        chk("orph.flag", 32'(orphan_done), 1);
        chk("orph.done_cnt", done_cnt, 6);
        chk("orph.last_lat", last_lat, 5);

        // done held without continue for three cycles
        do_reset();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            chk($sformatf("stall%0d.status", i), 32'(status), 2);
            chk($sformatf("stall%0d.cnt", i), stall_cnt, i + 1);
        end
        chk("stall.done_cnt", done_cnt, 0);
        drive(0, 0, 1, 1, 0);
        chk("stall.rel_done", done_cnt, 1);
        chk("stall.rel_cnt", stall_cnt, 3);
        chk("stall.rel_lat", last_lat, 4);
        chk("stall.rel_status", 32'(status), 0);
        chk("stall.busy", busy_cnt, 4);

        // unused slot: inputs tied low
        do_reset();
        idle(100);
        chk("tie0.status", 32'(status), 0);
        chk("tie0.counts", start_cnt | done_cnt | stall_cnt | busy_cnt, 0);
        chk("tie0.min_lat", min_lat, 32'hffff_ffff);
        chk("tie0.flags", {30'd0, ts_overflow, orphan_done}, 0);

        // finish in cycle 20 with a start in the same cycle
        do_reset();
        idle(20);
        drive(1, 1, 0, 0, 1);
        chk("fin.start_cnt", start_cnt, 1);
        chk("fin.status", 32'(status), 3);
        chk("fin.outstanding", 32'(outstanding), 1);
        for (int i = 0; i < 5; i++)
            drive(1, 1, 1, i[0], 0);
        chk("frz.start_cnt", start_cnt, 1);
        chk("frz.done_cnt", done_cnt, 0);
        chk("frz.stall_cnt", stall_cnt, 0);
        chk("frz.busy_cnt", busy_cnt, 0);
        chk("frz.status", 32'(status), 3);
        do_reset();
        chk("frz.rst_status", 32'(status), 0);
        chk("frz.rst_start_cnt", start_cnt, 0);

        // reset in the middle of a transaction discards the timestamp
        do_reset();
        drive(1, 1, 0, 0, 0);
        chk("mid.outstanding", 32'(outstanding), 1);
        do_reset();
        chk("mid.rst_out", 32'(outstanding), 0);
        drive(0, 0, 1, 1, 0);
        chk("mid.orphan", 32'(orphan_done), 1);
        chk("mid.min_lat", min_lat, 32'hffff_ffff);
        chk("mid.done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
